// File: rtl/spectro_column_ctrl.sv
// Spectrogram column controller: reads one spectrum frame of log-magnitude
// bins, streams them through an external color map, and writes the resulting
// RGB pixels as one framebuffer column. The write column advances after each
// frame, so the framebuffer works as a circular scrolling display.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for frame_valid && enable; ack is combinational here
// ISSUE   | one magnitude read per cycle, bins 0..NUM_BINS-1
// DRAIN   | 3 cycles letting the read/colormap/write pipeline empty
// DONE    | col_done pulse, write column advances (wraps), back to IDLE
module spectro_column_ctrl #(
  parameter  int NUM_BINS = 256,
  parameter  int NUM_COLS = 320,
  localparam int BIN_W    = $clog2(NUM_BINS),
  localparam int COL_W    = $clog2(NUM_COLS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   frame_valid,
  output logic                   frame_ack,
  output logic [BIN_W-1:0]       mag_addr,
  output logic                   mag_rd_en,
  input  logic [7:0]             mag_data,
  output logic [7:0]             cmap_log_val,
  output logic                   cmap_valid,
  input  logic [23:0]            cmap_rgb,
  input  logic                   cmap_valid_in,
  output logic                   fb_we,
  output logic [COL_W+BIN_W-1:0] fb_addr,
  output logic [23:0]            fb_data,
  output logic [COL_W-1:0]       write_col,
  output logic                   busy,
  output logic                   col_done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [BIN_W-1:0]         bin_q, bin_d;
  logic [COL_W-1:0]         write_col_q, write_col_d;
  logic                     rd_en_q, rd_en_d;
  logic [BIN_W-1:0]         addr_q, addr_d;
  logic                     tok1_q, tok1_d;
  logic [BIN_W-1:0]         row1_q, row1_d;
  logic                     tok2_q, tok2_d;
  logic [BIN_W-1:0]         row2_q, row2_d;
  logic                     fb_we_q, fb_we_d;
  logic [COL_W+BIN_W-1:0]   fb_addr_q, fb_addr_d;
  logic [23:0]              fb_data_q, fb_data_d;
  logic                     col_done_q, col_done_d;
  logic                     accept;

  // Next-state, counters and the pixel pipeline (read -> colormap -> write).
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    write_col_d = write_col_q;
    accept      = (state_q == S_IDLE) && frame_valid && enable && rst_n;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ISSUE;
          bin_d   = '0;
        end
      end
      S_ISSUE: begin
        // Last bin rolls the counter to 0, which then times the drain.
        bin_d = bin_q + 1'b1;
        if (bin_q == BIN_W'(NUM_BINS - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        bin_d = bin_q + 1'b1;
        if (bin_q == BIN_W'(2)) begin
          state_d = S_DONE;
          bin_d   = '0;
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        write_col_d = (write_col_q == COL_W'(NUM_COLS - 1)) ? '0 : write_col_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    rd_en_d    = (state_d == S_ISSUE);
    addr_d     = rd_en_d ? bin_d : '0;
    col_done_d = (state_d == S_DONE);

    // Tokens follow each read so stray colormap valids never write.
    tok1_d = rd_en_q;
    row1_d = rd_en_q ? addr_q : '0;
    tok2_d = tok1_q;
    row2_d = tok1_q ? row1_q : '0;

    // Row is mirrored so bin 0 lands on the bottom row.
    fb_we_d   = tok2_q && cmap_valid_in;
    fb_addr_d = fb_we_d ? {write_col_q, ~row2_q} : '0;
    fb_data_d = fb_we_d ? cmap_rgb : '0;
  end

  // State, counter and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      write_col_q <= '0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      tok1_q      <= 1'b0;
      row1_q      <= '0;
      tok2_q      <= 1'b0;
      row2_q      <= '0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
      col_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      write_col_q <= write_col_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      tok1_q      <= tok1_d;
      row1_q      <= row1_d;
      tok2_q      <= tok2_d;
      row2_q      <= row2_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
      col_done_q  <= col_done_d;
    end
  end

  assign frame_ack    = accept;
  assign mag_rd_en    = rd_en_q;
  assign mag_addr     = addr_q;
  assign cmap_valid   = tok1_q;
  assign cmap_log_val = tok1_q ? mag_data : 8'h00;
  assign fb_we        = fb_we_q;
  assign fb_addr      = fb_addr_q;
  assign fb_data      = fb_data_q;
  assign write_col    = write_col_q;
  assign busy         = (state_q != S_IDLE);
  assign col_done     = col_done_q;

endmodule

// File: tb/tb_spectro_column_ctrl.sv
// Scoreboard bench for spectro_column_ctrl: each accepted frame pushes its
// expected pixel writes and col_done cycle; a monitor pops and compares.
module tb_spectro_column_ctrl;

  localparam int NB   = 32;
  localparam int NC   = 320;
  localparam int BINW = $clog2(NB);
  localparam int COLW = $clog2(NC);

  logic                  clk, rst_n, enable, frame_valid, frame_ack;
  logic [BINW-1:0]       mag_addr;
  logic                  mag_rd_en;
  logic [7:0]            mag_data;
  logic [7:0]            cmap_log_val;
  logic                  cmap_valid;
  logic [23:0]           cmap_rgb;
  logic                  cmap_valid_in;
  logic                  fb_we;
  logic [COLW+BINW-1:0]  fb_addr;
  logic [23:0]           fb_data;
  logic [COLW-1:0]       write_col;
  logic                  busy, col_done;

  spectro_column_ctrl #(.NUM_BINS(NB), .NUM_COLS(NC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_valid(frame_valid),
    .frame_ack(frame_ack), .mag_addr(mag_addr), .mag_rd_en(mag_rd_en),
    .mag_data(mag_data), .cmap_log_val(cmap_log_val), .cmap_valid(cmap_valid),
    .cmap_rgb(cmap_rgb), .cmap_valid_in(cmap_valid_in), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .write_col(write_col),
    .busy(busy), .col_done(col_done)
  );

  typedef struct {
    int                   cyc;
    logic [COLW+BINW-1:0] addr;
    logic [23:0]          data;
  } wr_t;

  wr_t        wq[$];
  int         dq[$];
  logic [7:0] mem [NB];
  int         cyc = 0;
  int         n_cmp = 0, n_fail = 0;
  int         last_a = -100, next_ok = 0, model_col = 0;
  logic       spur;

  function automatic logic [23:0] cmap_fn(logic [7:0] v);
    return {v, v[3:0], v[7:4], ~v};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event missing (cycle %0d)", name, cyc);
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // External magnitude buffer and registered color map.
  initial begin
    logic c_rd, c_cv;
    logic [BINW-1:0] c_addr;
    logic [7:0] c_lv;
    mag_data = 0; cmap_rgb = 0; cmap_valid_in = 0;
    forever begin
      @(negedge clk);
      c_rd = mag_rd_en; c_addr = mag_addr; c_cv = cmap_valid | spur; c_lv = cmap_log_val;
      @(posedge clk);
      #1;
      mag_data      = c_rd ? mem[c_addr] : 8'($urandom);
      cmap_valid_in = c_cv;
      cmap_rgb      = cmap_fn(c_lv);
    end
  end

  // Monitor: reference model of acceptance plus scoreboard pops.
  initial forever begin
    logic exp_ack, exp_busy;
    wr_t w;
    @(negedge clk);
    if (!rst_n) begin
      chk("reset_outputs", {frame_ack, mag_rd_en, cmap_valid, fb_we, busy, col_done,
                            cmap_log_val, mag_addr, fb_addr, fb_data, write_col}, 0);
      wq.delete(); dq.delete();
      last_a = -100; next_ok = 0; model_col = 0;
      continue;
    end
    exp_ack  = frame_valid && enable && (cyc >= next_ok);
    exp_busy = (cyc > last_a) && (cyc < next_ok);
    chk("frame_ack", frame_ack, exp_ack);
    chk("busy", busy, exp_busy);
    if (exp_ack) begin
      chk("write_col_at_ack", write_col, model_col);
      last_a  = cyc;
      next_ok = cyc + NB + 5;
      for (int b = 0; b < NB; b++) begin
        w.cyc  = cyc + 4 + b;
        w.addr = {COLW'(model_col), BINW'(NB - 1 - b)};
        w.data = cmap_fn(mem[b]);
        wq.push_back(w);
      end
      dq.push_back(cyc + NB + 4);
      model_col = (model_col + 1) % NC;
    end
    if (fb_we) begin
      if (wq.size() == 0) chk("unexpected_fb_we", fb_we, 0);
      else begin
        w = wq.pop_front();
        chk("fb_we_cycle", cyc, w.cyc);
        chk("fb_addr", fb_addr, w.addr);
        chk("fb_data", fb_data, w.data);
      end
    end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
      fail_now("fb_we_missing");
      void'(wq.pop_front());
    end
    if (col_done) begin
      if (dq.size() == 0) chk("unexpected_col_done", col_done, 0);
      else chk("col_done_cycle", cyc, dq.pop_front());
    end else if (dq.size() > 0 && dq[0] <= cyc) begin
      fail_now("col_done_missing");
      void'(dq.pop_front());
    end
  end

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(int bound);
    bit got = 0;
    for (int k = 0; k < bound && !got; k++) begin
      @(negedge clk);
      if (frame_ack) got = 1;
    end
    if (!got) fail_now("ack_timeout");
    cycles(1);
  endtask

  task automatic wait_done(int bound);
    bit got = 0;
    for (int k = 0; k < bound && !got; k++) begin
      @(negedge clk);
      if (col_done) got = 1;
    end
    if (!got) fail_now("col_done_timeout");
    cycles(1);
  endtask

  task automatic rand_mem();
    for (int b = 0; b < NB; b++) mem[b] = 8'($urandom);
  endtask

  initial begin
    bit got;
    int k;
    rst_n = 0; enable = 0; frame_valid = 0; spur = 0;
    for (int b = 0; b < NB; b++) mem[b] = 8'(b);
    cycles(4);
    rst_n = 1;
    cycles(2);

    // Single frame with mag = bin index; bin 0 -> bottom row, blue.
    enable = 1; frame_valid = 1;
    wait_ack(10);
    frame_valid = 0;
    wait_done(NB + 20);
    chk("write_col_after_first", write_col, 1);

    // Stray colormap valid while idle.
    cycles(2);
    spur = 1;
    cycles(1);
    spur = 0;
    cycles(6);

    // frame_valid held through a column: second ack right after DONE.
    rand_mem();
    frame_valid = 1;
    wait_ack(10);
    wait_ack(NB + 20);
    frame_valid = 0;
    wait_done(NB + 20);

    // enable low blocks starts.
    enable = 0; frame_valid = 1;
    cycles(20);
    chk("no_start_disabled", busy, 0);
    frame_valid = 0;

    // enable dropped mid-column: column completes, no restart.
    rand_mem();
    enable = 1; frame_valid = 1;
    wait_ack(10);
    cycles(10);
    enable = 0;
    wait_done(NB + 20);
    cycles(15);
    frame_valid = 0; enable = 1;

    // Back-to-back frames across the write column wrap.
    rand_mem();
    frame_valid = 1;
    for (int f = 0; f < NC + 1; f++) wait_ack(NB + 20);
    frame_valid = 0;
    wait_done(NB + 20);

    // Reset in the middle of a column.
    rand_mem();
    frame_valid = 1;
    wait_ack(10);
    frame_valid = 0;
    got = 0;
    for (k = 0; k < NB + 10 && !got; k++) begin
      @(negedge clk);
      if (mag_rd_en && mag_addr == BINW'(20)) got = 1;
    end
    if (!got) fail_now("bin20_timeout");
    #2 rst_n = 0;
    #1;
    chk("async_reset_fb_we", fb_we, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_rd_en", mag_rd_en, 0);
    chk("async_reset_write_col", write_col, 0);
    cycles(3);
    rst_n = 1;
    cycles(6);
    rand_mem();
    frame_valid = 1;
    wait_ack(10);
    frame_valid = 0;
    wait_done(NB + 20);

    // Random frames with enable toggling while waiting for acceptance.
    for (int it = 0; it < 6; it++) begin
      rand_mem();
      cycles($urandom_range(0, 5));
      frame_valid = 1;
      got = 0;
      k = 0;
      while (!got && k < 60) begin
        enable = 1'($urandom);
        @(negedge clk);
        if (frame_ack) got = 1;
        cycles(1);
        k++;
      end
      if (!got) fail_now("random_ack_timeout");
      frame_valid = 0;
      enable = 1'($urandom);
      wait_done(NB + 20);
      enable = 1;
    end

    k = 0;
    while ((wq.size() != 0 || dq.size() != 0) && k < 100) begin
      cycles(1);
      k++;
    end
    chk("writes_outstanding", wq.size(), 0);
    chk("dones_outstanding", dq.size(), 0);
    cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
